// File: rtl/bitty_pkg.sv
// Shared constants and types for the Bitty serial instruction front-end.
package bitty_pkg;

    // Bitty instructions are always two bytes wide.
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned BYTE_W  = 8;

    // 10 MHz system clock, 115200 baud.
    localparam int unsigned CLKS_PER_BIT_DEF = 87;

    // Receiver frame states.
    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

endpackage

// File: rtl/bitty_uart_rx.sv
// 8N1 UART byte receiver: input synchronizer, baud counter and frame FSM.
// byte_valid_o and frame_err_o are single-cycle pulses asserted in the
// stop-bit sample cycle; byte_o is stable from then until the next frame.
module bitty_uart_rx
    import bitty_pkg::*;
#(
    // Legal values are 4 and above.
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_i,
    output logic [BYTE_W-1:0] byte_o,
    output logic              byte_valid_o,
    output logic              frame_err_o,
    output logic              rx_busy_o
);

    localparam int unsigned      CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic              r_sync_meta;
    logic              r_sync;
    logic              w_rx;
    rx_state_e         r_state;
    rx_state_e         w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit_idx;
    logic [BYTE_W-1:0] r_shift;
    logic              w_cnt_full;
    logic              w_cnt_half;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_meta <= 1'b1;
            r_sync      <= 1'b1;
        end else begin
            r_sync_meta <= rx_i;
            r_sync      <= r_sync_meta;
        end
    end

    assign w_rx       = r_sync;
    assign w_cnt_full = (r_cnt == CNT_FULL);
    assign w_cnt_half = (r_cnt == CNT_HALF);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (!w_rx) w_state_next = StStart;
            end
            StStart: begin
                // Mid-start resample: a line that has gone high again was a glitch.
                if (w_cnt_half) w_state_next = w_rx ? StIdle : StData;
            end
            StData: begin
                if (w_cnt_full && (r_bit_idx == 3'd7)) w_state_next = StStop;
            end
            StStop: begin
                if (w_cnt_full) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Baud counter, bit index and shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            // Restart on every state change and at the end of each bit period.
            if ((w_state_next != r_state) || w_cnt_full) begin
                r_cnt <= '0;
            end else if (r_state != StIdle) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if ((r_state == StStart) && w_cnt_half && !w_rx) begin
                r_bit_idx <= '0;
            end else if ((r_state == StData) && w_cnt_full) begin
                r_shift[r_bit_idx] <= w_rx;
                r_bit_idx          <= r_bit_idx + 3'd1;
            end
        end
    end

    // FSM outputs: stop-bit verdict pulses and busy flag.
    always_comb begin
        byte_valid_o = 1'b0;
        frame_err_o  = 1'b0;
        rx_busy_o    = (r_state != StIdle);
        if ((r_state == StStop) && w_cnt_full) begin
            if (w_rx) begin
                byte_valid_o = 1'b1;
            end else begin
                frame_err_o = 1'b1;
            end
        end
    end

    assign byte_o = r_shift;

endmodule

// File: rtl/bitty_uart_fetch.sv
// Bitty serial instruction front-end: pairs received UART bytes into 16-bit
// instructions (first byte high) and offers them to the core over valid/ready.
module bitty_uart_fetch
    import bitty_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic               frame_err_o,
    output logic               overflow_o,
    output logic               busy_o
);

    logic [BYTE_W-1:0]  w_byte;
    logic               w_byte_valid;
    logic               w_frame_err;
    logic               w_rx_busy;
    logic               w_word_done;
    logic               w_handshake;

    logic               r_ptr;
    logic [BYTE_W-1:0]  r_hi_byte;
    logic [INSTR_W-1:0] r_instr;
    logic               r_valid;
    logic               r_overflow;

    bitty_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .reset        (reset),
        .rx_i         (rx_i),
        .byte_o       (w_byte),
        .byte_valid_o (w_byte_valid),
        .frame_err_o  (w_frame_err),
        .rx_busy_o    (w_rx_busy)
    );

    assign w_word_done = w_byte_valid & r_ptr;
    assign w_handshake = r_valid & instr_ready_i;

    // Byte pointer and pending high byte; a framing error resyncs to a word boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr     <= 1'b0;
            r_hi_byte <= '0;
        end else if (w_frame_err) begin
            r_ptr <= 1'b0;
        end else if (w_byte_valid) begin
            if (!r_ptr) begin
                r_hi_byte <= w_byte;
                r_ptr     <= 1'b1;
            end else begin
                r_ptr <= 1'b0;
            end
        end
    end

    // Holding register: load when empty or being drained this cycle, else flag overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr    <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_word_done) begin
            if (!r_valid || w_handshake) begin
                r_instr <= {r_hi_byte, w_byte};
                r_valid <= 1'b1;
            end else begin
                r_overflow <= 1'b1;
            end
        end else if (w_handshake) begin
            r_valid <= 1'b0;
        end
    end

    assign instr_o       = r_instr;
    assign instr_valid_o = r_valid;
    assign overflow_o    = r_overflow;
    assign frame_err_o   = w_frame_err;
    assign busy_o        = w_rx_busy | r_ptr;

endmodule
